// File: rtl/left_shift_seq_pkg.sv
// Shared shift-path definitions: operand geometry, FSM encoding and barrel stage amounts.
package left_shift_seq_pkg;

    localparam int WIDTH      = 32;
    localparam int SHAMT_W    = 5;
    localparam int NUM_STAGES = 5;
    localparam int STAGE_W    = 3;

    localparam int STAGE_AMT_0 = 16;
    localparam int STAGE_AMT_1 = 8;
    localparam int STAGE_AMT_2 = 4;
    localparam int STAGE_AMT_3 = 2;
    localparam int STAGE_AMT_4 = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Stage 0 handles the largest amount so amt is consumed MSB first.
    function automatic logic [SHAMT_W-1:0] stage_amt(input logic [STAGE_W-1:0] stage);
        case (stage)
            3'd0:    stage_amt = SHAMT_W'(STAGE_AMT_0);
            3'd1:    stage_amt = SHAMT_W'(STAGE_AMT_1);
            3'd2:    stage_amt = SHAMT_W'(STAGE_AMT_2);
            3'd3:    stage_amt = SHAMT_W'(STAGE_AMT_3);
            default: stage_amt = SHAMT_W'(STAGE_AMT_4);
        endcase
    endfunction

endpackage

// File: rtl/left_shift_stage.sv
// One barrel stage: conditional zero-filling left shift by the amount selected by stage.
module left_shift_stage
    import left_shift_seq_pkg::*;
(
    input  logic [WIDTH-1:0]   din,
    input  logic [STAGE_W-1:0] stage,
    input  logic               en,
    output logic [WIDTH-1:0]   dout
);

    always_comb begin
        dout = din;
        if (en)
            dout = din << stage_amt(stage);
    end

endmodule

// File: rtl/left_shift_seq.sv
// Multi-cycle 32-bit logical left shifter: one barrel stage per clock, start/done handshake.
module left_shift_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic               ready,
    output logic               done,
    output logic [WIDTH-1:0]   result
);
    import left_shift_seq_pkg::*;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     stage_out;
    logic [SHAMT_W-1:0]   amt;
    logic [STAGE_W-1:0]   stage;
    logic [STAGE_W-1:0]   bit_sel;
    logic                 last_stage;

    assign bit_sel    = STAGE_W'(SHAMT_W - 1) - stage;
    assign last_stage = (stage == STAGE_W'(NUM_STAGES - 1));
    assign ready      = (state_q == IDLE);

    left_shift_stage u_stage (
        .din   (acc),
        .stage (stage),
        .en    (amt[bit_sel]),
        .dout  (stage_out)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_stage) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            acc     <= '0;
            amt     <= '0;
            stage   <= '0;
            result  <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc   <= data_operandA;
                        amt   <= ctrl_shiftamt;
                        stage <= '0;
                    end
                end
                SHIFT: begin
                    acc <= stage_out;
                    if (last_stage) begin
                        // Final stage output goes straight to result so done lines up with it.
                        result <= stage_out;
                        done   <= 1'b1;
                        stage  <= '0;
                    end else begin
                        stage <= stage + STAGE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_left_shift_seq.sv
// Scoreboard bench for left_shift_seq: stimulus pushes expectations, a negedge monitor pops on done.
module tb_left_shift_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] data_operandA;
    logic [4:0]  ctrl_shiftamt;
    logic        ready;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] exp;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   done_cnt    = 0;
    int   accepted    = 0;
    int   last_done   = -1;
    int   prev_done   = -1;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    left_shift_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .data_operandA (data_operandA),
        .ctrl_shiftamt (ctrl_shiftamt),
        .ready         (ready),
        .done          (done),
        .result        (result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (done) begin
            done_cnt++;
            prev_done = last_done;
            last_done = cyc;
            if (sb.size() == 0) begin
                fail("unexpected_done");
            end else begin
                e = sb.pop_front();
                check("result", result, e.exp);
                check("ready_with_done", {31'd0, ready}, 32'd1);
                check("latency", 32'(cyc - e.acc_cyc), 32'd5);
            end
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("ready_timeout");
    endtask

    task automatic issue(input logic [31:0] op, input logic [4:0] sh,
                         input logic [31:0] exp, input bit expect_done);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        start         = 1'b1;
        data_operandA = op;
        ctrl_shiftamt = sh;
        if (expect_done) begin
            sb.push_back('{exp, cyc + 1});
            accepted++;
        end
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            fail("drain_timeout");
            sb.delete();
        end
    endtask

    initial begin
        int          dc;
        int          first;
        bit          ok;
        logic [31:0] op;

        // start asserted alongside reset must be ignored
        reset         = 1'b1;
        start         = 1'b1;
        data_operandA = 32'hFFFF_FFFF;
        ctrl_shiftamt = 5'd3;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'h0);

        issue(32'h0000_0001, 5'd31, 32'h8000_0000, 1'b1);
        drain();
        issue(32'hF000_000F, 5'd4, 32'h0000_00F0, 1'b1);
        drain();
        issue(32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b1);
        drain();

        // Busy: start pulses and operand churn during SHIFT must be ignored
        dc = done_cnt;
        issue(32'h0000_00FF, 5'd8, 32'h0000_FF00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            start         = (i % 2 == 0);
            data_operandA = $urandom;
            ctrl_shiftamt = 5'($urandom_range(0, 31));
        end
        @(negedge clock);
        start = 1'b0;
        drain();
        repeat (8) @(negedge clock);
        check("busy_done_count", 32'(done_cnt - dc), 32'd1);

        // Back-to-back with start held high through the done cycle
        wait_ready(ok);
        if (ok) begin
            start         = 1'b1;
            data_operandA = 32'hA5A5_A5A5;
            ctrl_shiftamt = 5'd1;
            first         = cyc + 1;
            sb.push_back('{32'h4B4B_4B4A, first});
            sb.push_back('{32'h0001_0000, first + 6});
            accepted += 2;
            @(posedge clock);
            #1 data_operandA = 32'h0000_0001;
            ctrl_shiftamt = 5'd16;
            repeat (6) @(posedge clock);
            #1 start = 1'b0;
            drain();
            check("b2b_spacing", 32'(last_done - prev_done), 32'd6);
        end

        // Reset at E+3 aborts with no done pulse
        issue(32'h1234_5678, 5'd3, 32'h0, 1'b0);
        dc = done_cnt;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_result", result, 32'h0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (8) @(negedge clock);
        check("abort_no_done", 32'(done_cnt - dc), 32'd0);

        issue(32'h0000_0003, 5'd2, 32'h0000_000C, 1'b1);
        drain();

        for (int k = 0; k < 32; k++) begin
            op = $urandom;
            issue(op, 5'(k), op << k, 1'b1);
        end
        drain();

        check("done_vs_accepted", 32'(done_cnt), 32'(accepted));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/left_shift_seq.md
# left_shift_seq

Multi-cycle 32-bit logical left shifter for the processor's shift path. It is the left-direction counterpart of the single-cycle arithmetic right barrel shifter. It applies one barrel stage per clock (16, 8, 4, 2, 1) under a start/done handshake, which lets the ALU trade latency for area and timing margin. Vacated low bits are filled with 0.

## Interface
Parameters:
- WIDTH, 32, operand/result width; fixed at 32, which fixes stage amounts 16/8/4/2/1.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clock.
- start  in  1  request; accepted only on an edge where ready=1.
- data_operandA  in  WIDTH  operand; sampled on the accepting edge only.
- ctrl_shiftamt  in  SHAMT_W  shift amount 0..31; sampled on the accepting edge only.
- ready  out  1  high when IDLE and able to accept start.
- done  out  1  one-cycle pulse: result is valid and newly updated.
- result  out  WIDTH  final shifted value; held until the next done.

## Operation
- States:
  - IDLE: ready=1.
  - SHIFT: ready=0.
  - There is no separate DONE state.
- Internal registers:
  - acc[31:0]: working value.
  - amt[4:0]: latched shift amount.
  - stage[2:0]: stage counter, 0..4.
- IDLE & start: acc<=data_operandA, amt<=ctrl_shiftamt, stage<=0, state<=SHIFT.
- IDLE & !start: hold all state.
- SHIFT, each edge:
  - If amt[4-stage]=1, acc <= acc << (16>>stage), zero-filled, bits shifted out of bit 31 discarded. Otherwise acc holds.
  - stage<=stage+1.
- SHIFT with stage=4: after applying stage 4, result<=the stage-4 output, done<=1, state<=IDLE.
- Latency is fixed. All 5 stages always execute, including for shift amount 0. There is no early exit.
- start while ready=0 is ignored. It has no effect now and is not queued.
- Operands are captured at acceptance. Changes on data_operandA or ctrl_shiftamt during SHIFT do not affect the result.
- done is high for exactly one cycle per accepted request. It deasserts on the next edge unless that edge completes another operation, which is impossible at the minimum spacing.
- Reset has priority over every other event:
  - state<=IDLE, ready=1, done=0, result=0, acc=0, amt=0, stage=0.
  - Reset mid-operation aborts the operation with no done pulse; result reads 0.
  - start asserted together with reset is ignored.

## Timing
- Accepting edge E: start=1 and ready=1 are sampled.
- Edges E+1..E+5 apply stages 16, 8, 4, 2, 1 respectively.
- After edge E+5: done=1, ready=1, and result is valid in the same cycle.
- Latency is 5 cycles from the accepting edge to done.
- Back-to-back: start may be held high through the done cycle. The next accept occurs at edge E+6, giving one operation per 6 edges.
- ready is a registered function of state only. It has no combinational path from start.
- result changes only on the done edge or on reset.

## Structure
- Shared processor package holds:
  - WIDTH=32 and SHAMT_W=5.
  - State encoding: IDLE, SHIFT.
  - Stage-amount constants 16/8/4/2/1.
- Natural sub-module: left_shift_stage. It is a combinational conditional left shift of a WIDTH-bit input by a selectable stage amount, with an enable and zero-fill. One instance is indexed by stage each cycle.
- Top level contains the FSM, the stage counter, and the acc/amt/result registers.

## Test plan
- Basic shift: operand 0x0000_0001, amount 31, start at edge E → done pulse after E+5, ready high with it, result=0x8000_0000.
- Overflow and no-shift cases:
  - Operand 0xF000_000F, amount 4 → result=0x0000_00F0; high nibble discarded.
  - Amount 0 with operand 0xDEAD_BEEF → result=0xDEAD_BEEF, still after 5 cycles.
- Busy behaviour: while busy, pulse start with different operands, and toggle data_operandA and ctrl_shiftamt every cycle → result reflects only the originally captured pair, exactly one done pulse, no second operation launched.
- Back-to-back: start held high continuously with operand 0xA5A5_A5A5 and amount 1, then 0x1 and amount 16 → done pulses exactly 6 cycles apart, results 0x4B4B_4B4A then 0x0001_0000.
- Reset mid-operation: reset at edge E+3 → no done, ready=1 and result=0 the following cycle. A new request with operand 0x3 and amount 2 then completes with result=0xC.
- Exhaustive check: random operands across all 32 amounts → result equals operand << amount (32-bit truncate) every time; done count equals accepted-start count.
